linear_mac_sched: RTL and testbench

Sequencing controller for the time-multiplexed fully-connected layer: drives one shared MAC/accumulator datapath over OUT_FEATURES × IN_FEATURES products, issuing input-buffer, weight and bias read addresses. It tags returning memory beats with accumulate controls, schedules result write-back, and presents each output feature on a valid/ready stream with backpressure. It sits between the layer-start logic of the classifier head and the weight/bias memories plus MAC datapath.

---
 rtl/linear_pkg.sv | 22 ++
 rtl/linear_mac_sched_if.sv | 44 ++++
 rtl/linear_sched_pipe.sv | 33 +++
 rtl/linear_mac_sched.sv | 153 +++++++++++++++
 tb/tb_linear_mac_sched.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/linear_pkg.sv
// Shared types for the fully-connected layer sequencer: FSM states, beat tags
// travelling alongside memory reads, and the performance counter width.
package linear_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } sched_state_t;

    localparam int unsigned TAG_IDX_W = 16;
    localparam int unsigned PERF_W    = 32;

    typedef struct packed {
        logic                 valid;
        logic                 first;
        logic                 last;
        logic [TAG_IDX_W-1:0] idx;
    } beat_tag_t;

endpackage

// File: rtl/linear_mac_sched_if.sv
// Control, memory-read, accumulate and result-stream signals of the layer
// sequencer; master is the sequencer, slave is the surrounding datapath/consumer.
interface linear_mac_sched_if
    import linear_pkg::*;
#(
    parameter int unsigned IN_FEATURES  = 576,
    parameter int unsigned OUT_FEATURES = 1280
);
    localparam int unsigned IN_W = $clog2(IN_FEATURES);
    localparam int unsigned W_W  = $clog2(OUT_FEATURES * IN_FEATURES);
    localparam int unsigned B_W  = $clog2(OUT_FEATURES);

    logic              start;
    logic              busy;
    logic              done;
    logic              mem_rd;
    logic [IN_W-1:0]   in_addr;
    logic [W_W-1:0]    w_addr;
    logic [B_W-1:0]    b_addr;
    logic              acc_first;
    logic              acc_en;
    logic              acc_last;
    logic              wb_en;
    logic              out_valid;
    logic [B_W-1:0]    out_idx;
    logic              out_ready;
    logic [PERF_W-1:0] perf_cycles;
    logic [PERF_W-1:0] perf_stalls;

    modport master (
        input  start, out_ready,
        output busy, done, mem_rd, in_addr, w_addr, b_addr,
               acc_first, acc_en, acc_last, wb_en, out_valid, out_idx,
               perf_cycles, perf_stalls
    );

    modport slave (
        output start, out_ready,
        input  busy, done, mem_rd, in_addr, w_addr, b_addr,
               acc_first, acc_en, acc_last, wb_en, out_valid, out_idx,
               perf_cycles, perf_stalls
    );

endinterface

// File: rtl/linear_sched_pipe.sv
// Delay line that keeps beat tags aligned with memory read data; DEPTH equals
// the memory read latency. Cleared asynchronously so an abort drops in-flight beats.
module linear_sched_pipe
    import linear_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  beat_tag_t tag_in,
    output beat_tag_t tag_out,
    output logic      any_valid
);

    beat_tag_t stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) stage[k] <= '0;
        end else begin
            stage[0] <= tag_in;
            for (int unsigned k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
        end
    end

    assign tag_out = stage[DEPTH-1];

    always_comb begin
        any_valid = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) any_valid = any_valid | stage[k].valid;
    end

endmodule

// File: rtl/linear_mac_sched.sv
// Sequencer for the time-multiplexed fully-connected layer MAC datapath.
// Optional busy/stall performance counters are built when LINEAR_SCHED_PERF_EN is defined.
module linear_mac_sched
    import linear_pkg::*;
#(
    parameter int unsigned IN_FEATURES  = 576,
    parameter int unsigned OUT_FEATURES = 1280,
    parameter int unsigned MEM_LAT      = 1
) (
    input logic                clk,
    input logic                rst_n,
    linear_mac_sched_if.master bus
);

    localparam int unsigned IN_W = $clog2(IN_FEATURES);
    localparam int unsigned W_W  = $clog2(OUT_FEATURES * IN_FEATURES);
    localparam int unsigned B_W  = $clog2(OUT_FEATURES);

    sched_state_t    state, state_next;
    logic [IN_W-1:0] i_cnt;
    logic [B_W-1:0]  o_cnt;
    logic [W_W-1:0]  w_cnt;
    logic            rd;
    logic            stall;
    logic            row_end;
    logic            last_pos;
    logic            start_acc;
    logic            pipe_busy;
    beat_tag_t       tag_in, tag_out;
    logic            wb_q;
    logic [B_W-1:0]  wb_idx;
    logic            ov_q;
    logic [B_W-1:0]  out_idx_q;

    assign stall     = ov_q && !bus.out_ready;
    assign row_end   = (i_cnt == IN_W'(IN_FEATURES - 1));
    assign last_pos  = row_end && (o_cnt == B_W'(OUT_FEATURES - 1));
    assign start_acc = (state == IDLE) && bus.start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        rd         = 1'b0;
        unique case (state)
            IDLE:  if (bus.start) state_next = RUN;
            RUN: begin
                rd = !stall;
                if (!stall && last_pos) state_next = DRAIN;
            end
            // Leave only once no beat or write-back remains and the last row is taken.
            DRAIN: if (!pipe_busy && !wb_q && ov_q && bus.out_ready) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_cnt <= '0;
            o_cnt <= '0;
            w_cnt <= '0;
        end else if (start_acc) begin
            i_cnt <= '0;
            o_cnt <= '0;
            w_cnt <= '0;
        end else if (rd) begin
            if (row_end) begin
                i_cnt <= '0;
                o_cnt <= last_pos ? '0 : o_cnt + 1'b1;
            end else begin
                i_cnt <= i_cnt + 1'b1;
            end
            w_cnt <= last_pos ? '0 : w_cnt + 1'b1;
        end
    end

    always_comb begin
        tag_in       = '0;
        tag_in.valid = rd;
        tag_in.first = rd && (i_cnt == '0);
        tag_in.last  = rd && row_end;
        tag_in.idx   = TAG_IDX_W'(o_cnt);
    end

    linear_sched_pipe #(
        .DEPTH(MEM_LAT)
    ) u_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .tag_in   (tag_in),
        .tag_out  (tag_out),
        .any_valid(pipe_busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q      <= 1'b0;
            wb_idx    <= '0;
            ov_q      <= 1'b0;
            out_idx_q <= '0;
        end else begin
            wb_q <= tag_out.valid && tag_out.last;
            if (tag_out.valid && tag_out.last) wb_idx <= B_W'(tag_out.idx);
            if (wb_q) begin
                ov_q      <= 1'b1;
                out_idx_q <= wb_idx;
            end else if (ov_q && bus.out_ready) begin
                ov_q <= 1'b0;
            end
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.mem_rd    = rd;
    assign bus.in_addr   = i_cnt;
    assign bus.w_addr    = w_cnt;
    assign bus.b_addr    = o_cnt;
    assign bus.acc_en    = tag_out.valid;
    assign bus.acc_first = tag_out.valid && tag_out.first;
    assign bus.acc_last  = tag_out.valid && tag_out.last;
    assign bus.wb_en     = wb_q;
    assign bus.out_valid = ov_q;
    assign bus.out_idx   = out_idx_q;

`ifdef LINEAR_SCHED_PERF_EN
    logic [PERF_W-1:0] cyc_q, stl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
            stl_q <= '0;
        end else if (start_acc) begin
            cyc_q <= '0;
            stl_q <= '0;
        end else if (state != IDLE) begin
            if (cyc_q != '1)          cyc_q <= cyc_q + 1'b1;
            if (stall && stl_q != '1) stl_q <= stl_q + 1'b1;
        end
    end

    assign bus.perf_cycles = cyc_q;
    assign bus.perf_stalls = stl_q;
`else
    assign bus.perf_cycles = '0;
    assign bus.perf_stalls = '0;
`endif

endmodule

// File: tb/tb_linear_mac_sched.sv
// Directed bench for linear_mac_sched: per-cycle expectation tables for the
// IN=4/OUT=3/MEM_LAT=2 runs, plus reset-abort and back-to-back MEM_LAT=1 sequences.
module tb_linear_mac_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    linear_mac_sched_if #(.IN_FEATURES(4), .OUT_FEATURES(3)) ifa ();
    linear_mac_sched_if #(.IN_FEATURES(3), .OUT_FEATURES(2)) ifb ();

    linear_mac_sched #(.IN_FEATURES(4), .OUT_FEATURES(3), .MEM_LAT(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.master)
    );
    linear_mac_sched #(.IN_FEATURES(3), .OUT_FEATURES(2), .MEM_LAT(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.master)
    );

    typedef struct {
        bit st, rdy, rd;
        int ia, wa, ba;
        bit en, fi, la, wb, ov;
        int idx;
        bit dn, by;
    } vec_t;

    vec_t t1 [21];
    vec_t t2 [24];
    int   checks = 0;
    int   errors = 0;
    int   cur = 0;

    function automatic vec_t mk(bit st, bit rdy, bit rd, int ia, int wa, int ba, bit en,
                                bit fi, bit la, bit wb, bit ov, int idx, bit dn, bit by);
        vec_t v;
        v.st = st; v.rdy = rdy; v.rd = rd; v.ia = ia; v.wa = wa; v.ba = ba;
        v.en = en; v.fi = fi; v.la = la; v.wb = wb; v.ov = ov; v.idx = idx;
        v.dn = dn; v.by = by;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0d expected %0d", nm, cur, act, exp);
        end
    endtask

    task automatic apply(input int sel, input int n, input bit extra);
        vec_t v;
        for (int c = 0; c < n; c++) begin
            v = (sel == 1) ? t1[c] : t2[c];
            @(posedge clk); #1;
            ifa.start     = v.st | (extra && (c == 5 || c == 17));
            ifa.out_ready = v.rdy;
            #1;
            cur = c;
            chk("mem_rd", int'(ifa.mem_rd), int'(v.rd));
            if (v.rd) begin
                chk("in_addr", int'(ifa.in_addr), v.ia);
                chk("w_addr", int'(ifa.w_addr), v.wa);
                chk("b_addr", int'(ifa.b_addr), v.ba);
            end
            chk("acc_en", int'(ifa.acc_en), int'(v.en));
            chk("acc_first", int'(ifa.acc_first), int'(v.fi));
            chk("acc_last", int'(ifa.acc_last), int'(v.la));
            chk("wb_en", int'(ifa.wb_en), int'(v.wb));
            chk("out_valid", int'(ifa.out_valid), int'(v.ov));
            if (v.ov) chk("out_idx", int'(ifa.out_idx), v.idx);
            chk("done", int'(ifa.done), int'(v.dn));
            chk("busy", int'(ifa.busy), int'(v.by));
        end
        ifa.start     = 1'b0;
        ifa.out_ready = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_mem_rd"}, int'(ifa.mem_rd), 0);
        chk({tag, "_in_addr"}, int'(ifa.in_addr), 0);
        chk({tag, "_w_addr"}, int'(ifa.w_addr), 0);
        chk({tag, "_b_addr"}, int'(ifa.b_addr), 0);
        chk({tag, "_acc_en"}, int'(ifa.acc_en), 0);
        chk({tag, "_acc_first"}, int'(ifa.acc_first), 0);
        chk({tag, "_acc_last"}, int'(ifa.acc_last), 0);
        chk({tag, "_wb_en"}, int'(ifa.wb_en), 0);
        chk({tag, "_out_valid"}, int'(ifa.out_valid), 0);
        chk({tag, "_out_idx"}, int'(ifa.out_idx), 0);
        chk({tag, "_busy"}, int'(ifa.busy), 0);
        chk({tag, "_done"}, int'(ifa.done), 0);
        chk({tag, "_perf_cycles"}, int'(ifa.perf_cycles), 0);
        chk({tag, "_perf_stalls"}, int'(ifa.perf_stalls), 0);
    endtask

    initial begin
        //            st rdy rd ia wa ba en fi la wb ov idx dn by
        t1[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        t1[1]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        t1[2]  = mk(0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        t1[3]  = mk(0, 1, 1, 2, 2, 0, 1, 1, 0, 0, 0, 0, 0, 1);
        t1[4]  = mk(0, 1, 1, 3, 3, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        t1[5]  = mk(0, 1, 1, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        t1[6]  = mk(0, 1, 1, 1, 5, 1, 1, 0, 1, 0, 0, 0, 0, 1);
        t1[7]  = mk(0, 1, 1, 2, 6, 1, 1, 1, 0, 1, 0, 0, 0, 1);
        t1[8]  = mk(0, 1, 1, 3, 7, 1, 1, 0, 0, 0, 1, 0, 0, 1);
        t1[9]  = mk(0, 1, 1, 0, 8, 2, 1, 0, 0, 0, 0, 0, 0, 1);
        t1[10] = mk(0, 1, 1, 1, 9, 2, 1, 0, 1, 0, 0, 0, 0, 1);
        t1[11] = mk(0, 1, 1, 2, 10, 2, 1, 1, 0, 1, 0, 0, 0, 1);
        t1[12] = mk(0, 1, 1, 3, 11, 2, 1, 0, 0, 0, 1, 1, 0, 1);
        t1[13] = mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        t1[14] = mk(0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1);
        t1[15] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        t1[16] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 1);
        t1[17] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        t1[18] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        t1[19] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        t1[20] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        t2[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        t2[1]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        t2[2]  = mk(0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        t2[3]  = mk(0, 1, 1, 2, 2, 0, 1, 1, 0, 0, 0, 0, 0, 1);
        t2[4]  = mk(0, 1, 1, 3, 3, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        t2[5]  = mk(0, 1, 1, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        t2[6]  = mk(0, 1, 1, 1, 5, 1, 1, 0, 1, 0, 0, 0, 0, 1);
        t2[7]  = mk(0, 1, 1, 2, 6, 1, 1, 1, 0, 1, 0, 0, 0, 1);
        t2[8]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1);
        t2[9]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1);
        t2[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        t2[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        t2[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        t2[13] = mk(0, 1, 1, 3, 7, 1, 0, 0, 0, 0, 1, 0, 0, 1);
        t2[14] = mk(0, 1, 1, 0, 8, 2, 0, 0, 0, 0, 0, 0, 0, 1);
        t2[15] = mk(0, 1, 1, 1, 9, 2, 1, 0, 1, 0, 0, 0, 0, 1);
        t2[16] = mk(0, 1, 1, 2, 10, 2, 1, 1, 0, 1, 0, 0, 0, 1);
        t2[17] = mk(0, 1, 1, 3, 11, 2, 1, 0, 0, 0, 1, 1, 0, 1);
        t2[18] = mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        t2[19] = mk(0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1);
        t2[20] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        t2[21] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 1);
        t2[22] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        t2[23] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        ifa.start = 1'b0; ifa.out_ready = 1'b1;
        ifb.start = 1'b0; ifb.out_ready = 1'b1;

        #1 check_zero("reset");
        #21 rst_n = 1'b1;

        // Basic run, then a stalled run with counter readout.
        apply(1, 21, 1'b0);
        apply(2, 24, 1'b0);
        cur = 24;
`ifdef LINEAR_SCHED_PERF_EN
        chk("perf_cycles", int'(ifa.perf_cycles), 22);
        chk("perf_stalls", int'(ifa.perf_stalls), 5);
`else
        chk("perf_cycles", int'(ifa.perf_cycles), 0);
        chk("perf_stalls", int'(ifa.perf_stalls), 0);
`endif

        // Extra start pulses during RUN and DONE must not disturb or restart.
        apply(1, 21, 1'b1);

        // Abort at cycle 9 while a result is held, then a clean rerun.
        apply(2, 9, 1'b0);
        @(posedge clk); #1;
        ifa.out_ready = 1'b0;
        rst_n = 1'b0;
        #1 cur = 9;
        check_zero("abort");
        @(posedge clk); #1;
        rst_n = 1'b1;
        ifa.out_ready = 1'b1;
        apply(1, 21, 1'b0);

        // MEM_LAT=1, IN=3, OUT=2: two back-to-back runs started at cycles 0 and 11.
        for (int c = 0; c <= 22; c++) begin
            bit exp_rd;
            @(posedge clk); #1;
            ifb.start = (c == 0 || c == 11);
            ifb.out_ready = 1'b1;
            #1;
            cur = c;
            exp_rd = (c >= 1 && c <= 6) || (c >= 12 && c <= 17);
            chk("b_mem_rd", int'(ifb.mem_rd), int'(exp_rd));
            if (exp_rd) chk("b_w_addr", int'(ifb.w_addr), (c <= 6) ? c - 1 : c - 12);
            chk("b_acc_last", int'(ifb.acc_last), int'(c == 4 || c == 7 || c == 15 || c == 18));
            chk("b_done", int'(ifb.done), int'(c == 10 || c == 21));
`ifndef LINEAR_SCHED_PERF_EN
            chk("b_perf_cycles", int'(ifb.perf_cycles), 0);
`endif
        end
        ifb.start = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
